segway_ctrl_seq: RTL and testbench

//  Sequencer for the segway balance math datapath. Drives pwr_up, the 8-bit soft-start ramp ss_tmr and en_steer.

---
 rtl/segway_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_segway_ctrl_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segway_ctrl_seq.sv
// Power-up / soft-start / steering / overspeed sequencer for the segway balance datapath.
// Outputs are decoded from the registered state and counters only.
module segway_ctrl_seq #(
  parameter int SS_CNT_W  = 20,
  parameter int OVR_CNT   = 3,
  parameter int STEER_DLY = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_btn,
  input  logic       rider_on,
  input  logic       steer_req,
  input  logic       nxt,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       ovr_spd,
  output logic [2:0] state
);

  localparam int OVR_W   = $clog2(OVR_CNT + 1);
  localparam int STEER_W = $clog2(STEER_DLY + 1);
  localparam logic [SS_CNT_W-1:0] SS_ALL    = '1;
  localparam logic [OVR_W-1:0]    OVR_MAX   = OVR_W'(OVR_CNT);
  localparam logic [STEER_W-1:0]  STEER_MAX = STEER_W'(STEER_DLY);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WAIT  = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [SS_CNT_W-1:0] ss_cnt_q, ss_cnt_d, ss_inc;
  logic [STEER_W-1:0]  steer_cnt_q, steer_cnt_d, steer_inc;
  logic [OVR_W-1:0]    ovr_cnt_q, ovr_cnt_d, ovr_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      ss_cnt_q    <= '0;
      steer_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ss_cnt_q    <= ss_cnt_d;
      steer_cnt_q <= steer_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ss_cnt_d    = ss_cnt_q;
    steer_cnt_d = steer_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    ss_inc      = (ss_cnt_q == SS_ALL) ? SS_ALL : ss_cnt_q + SS_CNT_W'(1);
    steer_inc   = (steer_cnt_q == STEER_MAX) ? STEER_MAX : steer_cnt_q + STEER_W'(1);
    ovr_inc     = ovr_cnt_q + OVR_W'(1);

    if (!pwr_btn) begin
      state_d     = S_OFF;
      ss_cnt_d    = '0;
      steer_cnt_d = '0;
      ovr_cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d     = S_WAIT;
          ss_cnt_d    = '0;
          steer_cnt_d = '0;
          ovr_cnt_d   = '0;
        end
        S_WAIT: begin
          ss_cnt_d    = '0;
          steer_cnt_d = '0;
          ovr_cnt_d   = '0;
          if (rider_on) state_d = S_RAMP;
        end
        S_RAMP: begin
          steer_cnt_d = '0;
          ovr_cnt_d   = '0;
          if (!rider_on) begin
            state_d  = S_WAIT;
            ss_cnt_d = '0;
          end else begin
            // The edge that makes the ramp full is also the edge that enters RUN.
            ss_cnt_d = ss_inc;
            if (ss_inc == SS_ALL) state_d = S_RUN;
          end
        end
        S_RUN: begin
          ss_cnt_d = SS_ALL;
          if (!rider_on) begin
            state_d     = S_WAIT;
            ss_cnt_d    = '0;
            steer_cnt_d = '0;
            ovr_cnt_d   = '0;
          end else if (nxt && too_fast && (ovr_inc == OVR_MAX)) begin
            state_d     = S_FAULT;
            steer_cnt_d = '0;
            ovr_cnt_d   = '0;
          end else begin
            if (nxt) ovr_cnt_d = too_fast ? ovr_inc : '0;
            // Dropping steer_req disqualifies steering immediately, not on the next sample.
            if (!steer_req) steer_cnt_d = '0;
            else if (nxt)   steer_cnt_d = steer_inc;
          end
        end
        S_FAULT: begin
          ss_cnt_d    = SS_ALL;
          steer_cnt_d = '0;
          if (!rider_on) begin
            state_d   = S_WAIT;
            ss_cnt_d  = '0;
            ovr_cnt_d = '0;
          end else if (nxt) begin
            if (!too_fast && (ovr_inc == OVR_MAX)) begin
              state_d   = S_RUN;
              ovr_cnt_d = '0;
            end else begin
              ovr_cnt_d = too_fast ? '0 : ovr_inc;
            end
          end
        end
        default: begin
          state_d     = S_OFF;
          ss_cnt_d    = '0;
          steer_cnt_d = '0;
          ovr_cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pwr_up   = 1'b0;
    ss_tmr   = 8'h00;
    en_steer = 1'b0;
    ovr_spd  = 1'b0;
    state    = state_q;
    case (state_q)
      S_WAIT:  pwr_up = 1'b1;
      S_RAMP: begin
        pwr_up = 1'b1;
        ss_tmr = ss_cnt_q[SS_CNT_W-1 -: 8];
      end
      S_RUN: begin
        pwr_up   = 1'b1;
        ss_tmr   = 8'hFF;
        en_steer = (steer_cnt_q == STEER_MAX);
      end
      S_FAULT: begin
        pwr_up  = 1'b1;
        ss_tmr  = 8'hFF;
        ovr_spd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_segway_ctrl_seq.sv
// Bench for segway_ctrl_seq: directed scenarios followed by biased random inputs,
// every cycle compared against a rule-level reference model through an expected queue.
module tb_segway_ctrl_seq;

  localparam int SS_CNT_W  = 10;
  localparam int OVR_CNT   = 3;
  localparam int STEER_DLY = 4;
  localparam int SS_MAX    = (1 << SS_CNT_W) - 1;

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RAMP  = 2;
  localparam int M_RUN   = 3;
  localparam int M_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst_n, pwr_btn, rider_on, steer_req, nxt, too_fast;
  logic       pwr_up, en_steer, ovr_spd;
  logic [7:0] ss_tmr;
  logic [2:0] state;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: mode plus "how far along" figures for each rule
  int m_state = M_OFF;
  int m_ss    = 0;
  int m_steer = 0;
  int m_ovr   = 0;

  logic [13:0] exp_q[$];

  segway_ctrl_seq #(
    .SS_CNT_W (SS_CNT_W),
    .OVR_CNT  (OVR_CNT),
    .STEER_DLY(STEER_DLY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_btn  (pwr_btn),
    .rider_on (rider_on),
    .steer_req(steer_req),
    .nxt      (nxt),
    .too_fast (too_fast),
    .pwr_up   (pwr_up),
    .ss_tmr   (ss_tmr),
    .en_steer (en_steer),
    .ovr_spd  (ovr_spd),
    .state    (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic clear_model();
    m_ss    = 0;
    m_steer = 0;
    m_ovr   = 0;
  endtask

  task automatic model_edge();
    if (!rst_n || !pwr_btn) begin
      m_state = M_OFF;
      clear_model();
    end else if (m_state == M_OFF) begin
      m_state = M_WAIT;
    end else if (m_state == M_WAIT) begin
      if (rider_on) m_state = M_RAMP;
    end else if (m_state == M_RAMP) begin
      if (!rider_on) begin
        m_state = M_WAIT;
        clear_model();
      end else begin
        m_ss = (m_ss < SS_MAX) ? m_ss + 1 : SS_MAX;
        if (m_ss == SS_MAX) m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (!rider_on) begin
        m_state = M_WAIT;
        clear_model();
      end else begin
        if (nxt) m_ovr = too_fast ? m_ovr + 1 : 0;
        if (m_ovr == OVR_CNT) begin
          m_state = M_FAULT;
          m_ovr   = 0;
          m_steer = 0;
        end else if (!steer_req) begin
          m_steer = 0;
        end else if (nxt && m_steer < STEER_DLY) begin
          m_steer = m_steer + 1;
        end
      end
    end else begin
      if (!rider_on) begin
        m_state = M_WAIT;
        clear_model();
      end else if (nxt) begin
        m_ovr = too_fast ? 0 : m_ovr + 1;
        if (m_ovr == OVR_CNT) begin
          m_state = M_RUN;
          m_ovr   = 0;
          m_steer = 0;
        end
      end
    end
  endtask

  function automatic logic [13:0] model_out();
    int tmr;
    if (m_state == M_RAMP) tmr = m_ss / (1 << (SS_CNT_W - 8));
    else if (m_state == M_RUN || m_state == M_FAULT) tmr = 255;
    else tmr = 0;
    return {3'(m_state), (m_state != M_OFF), 8'(tmr),
            (m_state == M_RUN && m_steer == STEER_DLY), (m_state == M_FAULT)};
  endfunction

  // driver: one clock with the current inputs, then scoreboard compare
  task automatic tick();
    logic [13:0] want;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
    want = exp_q.pop_front();
    check("state",    32'(state),    32'(want[13:11]));
    check("pwr_up",   32'(pwr_up),   32'(want[10]));
    check("ss_tmr",   32'(ss_tmr),   32'(want[9:2]));
    check("en_steer", 32'(en_steer), 32'(want[1]));
    check("ovr_spd",  32'(ovr_spd),  32'(want[0]));
  endtask

  task automatic pulse_nxt(input logic tf, input int gap);
    too_fast = tf;
    nxt      = 1'b1;
    tick();
    nxt = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_run(input string tag);
    int k = 0;
    while (state !== 3'd3 && k < 1100) begin
      tick();
      k++;
    end
    check(tag, 32'(k), 32'd1023);
  endtask

  initial begin
    rst_n = 1'b0; pwr_btn = 1'b0; rider_on = 1'b0;
    steer_req = 1'b0; nxt = 1'b0; too_fast = 1'b0;
    #1;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ss_tmr", 32'(ss_tmr), 32'd0);

    // power up and full soft-start ramp
    rst_n = 1'b1; pwr_btn = 1'b1; rider_on = 1'b1;
    tick();
    check("wait_entry", 32'(state), 32'd1);
    tick();
    check("ramp_entry", 32'(state), 32'd2);
    wait_run("ramp_len");
    check("run_ss_tmr", 32'(ss_tmr), 32'hFF);

    // steering qualification
    steer_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      check("steer_qual", 32'(en_steer), (i == 3) ? 32'd1 : 32'd0);
      repeat (7) tick();
    end
    steer_req = 1'b0;
    tick();
    check("steer_drop", 32'(en_steer), 32'd0);

    // overspeed: interrupted streak does not fault, full streak does
    steer_req = 1'b1;
    pulse_nxt(1'b1, 8);
    pulse_nxt(1'b1, 8);
    pulse_nxt(1'b0, 8);
    check("ovr_broken", 32'(state), 32'd3);
    pulse_nxt(1'b1, 8);
    pulse_nxt(1'b1, 8);
    check("ovr_two", 32'(state), 32'd3);
    check("steer_before_fault", 32'(en_steer), 32'd1);
    pulse_nxt(1'b1, 1);
    check("fault_entry", 32'(state), 32'd4);
    check("fault_ovr_spd", 32'(ovr_spd), 32'd1);
    check("fault_en_steer", 32'(en_steer), 32'd0);
    repeat (3) pulse_nxt(1'b0, 4);
    check("fault_exit", 32'(state), 32'd3);
    check("exit_ovr_spd", 32'(ovr_spd), 32'd0);
    check("exit_requal", 32'(en_steer), 32'd0);

    // overspeed completion coinciding with rider leaving
    pulse_nxt(1'b1, 2);
    pulse_nxt(1'b1, 2);
    too_fast = 1'b1; nxt = 1'b1; rider_on = 1'b0;
    tick();
    nxt = 1'b0; too_fast = 1'b0;
    check("simul_state", 32'(state), 32'd1);
    check("simul_ovr_spd", 32'(ovr_spd), 32'd0);

    // rider drop mid-ramp restarts the ramp
    rider_on = 1'b1;
    tick();
    repeat (512) tick();
    check("mid_ramp", 32'(ss_tmr), 32'h80);
    rider_on = 1'b0;
    tick();
    check("drop_state", 32'(state), 32'd1);
    check("drop_ss_tmr", 32'(ss_tmr), 32'd0);
    rider_on = 1'b1;
    tick();
    check("restart_ss_tmr", 32'(ss_tmr), 32'd0);
    repeat (4) tick();
    check("restart_step", 32'(ss_tmr), 32'd1);

    // synchronous reset mid-ramp
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_pwr_up", 32'(pwr_up), 32'd0);
    check("rst_mid_ss_tmr", 32'(ss_tmr), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    wait_run("ramp_len2");

    // power button drop from FAULT
    repeat (3) pulse_nxt(1'b1, 3);
    check("fault2_entry", 32'(state), 32'd4);
    pwr_btn = 1'b0;
    tick();
    check("btn_off_state", 32'(state), 32'd0);
    check("btn_off_ovr_spd", 32'(ovr_spd), 32'd0);
    check("btn_off_ss_tmr", 32'(ss_tmr), 32'd0);
    check("btn_off_pwr_up", 32'(pwr_up), 32'd0);

    // biased random stress
    for (int i = 0; i < 9000; i++) begin
      rst_n     = ($urandom_range(0, 2999) != 0);
      pwr_btn   = ($urandom_range(0, 2499) != 0);
      rider_on  = ($urandom_range(0, 1199) != 0);
      steer_req = ($urandom_range(0, 11) != 0);
      nxt       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) too_fast = ~too_fast;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
